// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller blocks (arbiter, refresh,
// read and write sequencers): command encodings, FSM state codes and
// default timing.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  // One-hot sequencer states
  localparam logic [7:0] S_IDLE  = 8'b0000_0001;
  localparam logic [7:0] S_REQ   = 8'b0000_0010;
  localparam logic [7:0] S_ACT   = 8'b0000_0100;
  localparam logic [7:0] S_RCD   = 8'b0000_1000;
  localparam logic [7:0] S_WRITE = 8'b0001_0000;
  localparam logic [7:0] S_TWR   = 8'b0010_0000;
  localparam logic [7:0] S_PRE   = 8'b0100_0000;
  localparam logic [7:0] S_TRP   = 8'b1000_0000;

  // Address bit that selects all-bank PRECHARGE / auto-precharge
  localparam int A10_BIT = 10;

  // Default geometry and timing
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ROW_W     = 12;
  localparam int DEF_COL_W     = 9;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_T_RCD     = 2;
  localparam int DEF_T_WR      = 2;
  localparam int DEF_T_RP      = 2;

endpackage

// File: rtl/sdram_addr_cnt.sv
// Column/row/bank address counters for the write sequencer. Column steps one
// burst at a time and wraps at row end; row steps per finished job and
// carries into the 2-bit bank counter.
module sdram_addr_cnt
  import sdram_pkg::*;
#(
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             burst_done,
  input  logic             job_done,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [1:0]       bank,
  output logic             last_burst
);

  // A row is a whole number of bursts, so plain modulo addition wraps to 0
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(BURST_LEN);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'((1 << COL_W) - BURST_LEN);

  assign last_burst = (col == COL_LAST);

  // Column advances after the last beat of every burst
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)        col <= '0;
    else if (burst_done) col <= col + COL_STEP;
  end

  // Row advances per completed row; row wrap carries into bank
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      row  <= '0;
      bank <= '0;
    end else if (job_done) begin
      row <= row + ROW_W'(1);
      if (&row) bank <= bank + 2'd1;
    end
  end

endmodule

// File: rtl/sdram_write.sv
// SDRAM write-burst sequencer. Requests the bus, then writes one full row in
// gapless bursts (ACTIVE, WRITE..., PRECHARGE). A pending refresh breaks the
// row at a burst boundary; the job re-requests and resumes at the next column.
// Outputs are decoded from registered state so reset clears them at once.
module sdram_write
  import sdram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int T_RCD     = DEF_T_RCD,   // >= 2
  parameter int T_WR      = DEF_T_WR,    // >= 2
  parameter int T_RP      = DEF_T_RP
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              wr_trig,
  input  logic              wr_en,
  input  logic              ref_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_req,
  output logic              flag_wr_end,
  output logic              wr_busy,
  output logic              wr_data_rd,
  output logic [3:0]        wr_cmd,
  output logic [1:0]        wr_bank,
  output logic [ROW_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_dq,
  output logic              wr_dq_oe
);

  // Timer end values: RCD/TWR hold (T-1) NOPs, TRP holds T_RP NOPs plus the
  // flag cycle.
  localparam logic [7:0]       RCD_LAST  = 8'(T_RCD - 2);
  localparam logic [7:0]       BEAT_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0]       TWR_LAST  = 8'(T_WR - 2);
  localparam logic [7:0]       TRP_LAST  = 8'(T_RP);
  localparam logic [ROW_W-1:0] ADDR_A10  = ROW_W'(1 << A10_BIT);

  logic [7:0]       state, tmr;
  logic             row_done, last_burst, last_beat, trp_end, job_done;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [1:0]       bank;

  assign last_beat = (state == S_WRITE) && (tmr == BEAT_LAST);
  assign trp_end   = (state == S_TRP) && (tmr == TRP_LAST);
  assign job_done  = trp_end && row_done;

  sdram_addr_cnt #(
    .ROW_W    (ROW_W),
    .COL_W    (COL_W),
    .BURST_LEN(BURST_LEN)
  ) u_addr_cnt (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .burst_done(last_beat),
    .job_done  (job_done),
    .col       (col),
    .row       (row),
    .bank      (bank),
    .last_burst(last_burst)
  );

  // Sequencer FSM; tmr counts cycles within a state and is cleared on entry
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      row_done <= 1'b0;
    end else begin
      tmr <= tmr + 8'd1;
      case (state)
        S_IDLE: if (wr_trig) state <= S_REQ;
        S_REQ:  if (wr_en) state <= S_ACT;
        S_ACT: begin
          state <= S_RCD;
          tmr   <= '0;
        end
        S_RCD: if (tmr == RCD_LAST) begin
          state <= S_WRITE;
          tmr   <= '0;
        end
        // refresh is only honoured at a burst boundary
        S_WRITE: if (last_beat) begin
          tmr <= '0;
          if (last_burst || ref_req) begin
            state    <= S_TWR;
            row_done <= last_burst;
          end
        end
        S_TWR: if (tmr == TWR_LAST) begin
          state <= S_PRE;
          tmr   <= '0;
        end
        S_PRE: begin
          state <= S_TRP;
          tmr   <= '0;
        end
        S_TRP: if (trp_end) begin
          state    <= row_done ? S_IDLE : S_REQ;
          row_done <= 1'b0;
          tmr      <= '0;
        end
        default: begin
          state <= S_IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

  // Command/address decode from the current state
  always_comb begin
    wr_cmd  = CMD_NOP;
    wr_bank = '0;
    wr_addr = '0;
    case (state)
      S_ACT: begin
        wr_cmd  = CMD_ACT;
        wr_bank = bank;
        wr_addr = row;
      end
      S_WRITE: if (tmr == '0) begin
        wr_cmd  = CMD_WR;
        wr_bank = bank;
        wr_addr = ROW_W'(col);
      end
      S_PRE: begin
        wr_cmd  = CMD_PRE;
        wr_addr = ADDR_A10;
      end
      default: ;
    endcase
  end

  assign wr_req      = (state == S_REQ);
  assign wr_busy     = (state != S_IDLE);
  assign wr_dq_oe    = (state == S_WRITE);
  assign wr_data_rd  = wr_dq_oe;
  assign wr_dq       = wr_dq_oe ? wr_data : '0;
  assign flag_wr_end = trp_end;

endmodule

// File: tb/tb_sdram_write.sv
// Bench for sdram_write: directed job sequence with random data, grant
// delays and refresh points, checked against a transaction-level model of
// the expected column/row/bank progression. A second instance with one burst
// per row exercises the row->bank wrap.
module tb_sdram_write;
  import sdram_pkg::*;

  localparam int DW = 16;
  localparam int RW = 12;
  localparam int CW = 9;
  localparam int BL = 4;
  localparam int NJOB2 = (1 << RW) + 1;

  logic          sclk = 1'b0;
  logic          s_rst_n = 1'b0, s2_rst_n = 1'b0;
  logic          wr_trig = 1'b0, wr_en = 1'b0, ref_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_req, flag_wr_end, wr_busy, wr_data_rd, wr_dq_oe;
  logic [3:0]    wr_cmd;
  logic [1:0]    wr_bank;
  logic [RW-1:0] wr_addr;
  logic [DW-1:0] wr_dq;

  logic          s2_trig = 1'b0, s2_en = 1'b0;
  logic          s2_req, s2_flag, s2_busy, s2_rd, s2_oe;
  logic [3:0]    s2_cmd;
  logic [1:0]    s2_bank;
  logic [RW-1:0] s2_addr;
  logic [DW-1:0] s2_dq;

  int checks = 0, errors = 0;

  always #5 sclk = ~sclk;

  sdram_write dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .wr_trig(wr_trig), .wr_en(wr_en),
    .ref_req(ref_req), .wr_data(wr_data), .wr_req(wr_req),
    .flag_wr_end(flag_wr_end), .wr_busy(wr_busy), .wr_data_rd(wr_data_rd),
    .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_dq(wr_dq),
    .wr_dq_oe(wr_dq_oe)
  );

  sdram_write #(.COL_W(2)) dut2 (
    .sclk(sclk), .s_rst_n(s2_rst_n), .wr_trig(s2_trig), .wr_en(s2_en),
    .ref_req(1'b0), .wr_data(wr_data), .wr_req(s2_req),
    .flag_wr_end(s2_flag), .wr_busy(s2_busy), .wr_data_rd(s2_rd),
    .wr_cmd(s2_cmd), .wr_bank(s2_bank), .wr_addr(s2_addr), .wr_dq(s2_dq),
    .wr_dq_oe(s2_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // show-ahead FIFO head: new random word every cycle
  initial forever begin
    @(posedge sclk);
    #1 wr_data = DW'($urandom);
  end

  // Model: expected next column, row, bank; beats still owed by the last WRITE
  int exp_col, exp_row, exp_bank, beats_left;
  always @(negedge sclk) begin
    if (!s_rst_n) begin
      exp_col = 0; exp_row = 0; exp_bank = 0; beats_left = 0;
    end else begin
      case (wr_cmd)
        CMD_ACT: begin
          chk("act_bank", wr_bank, exp_bank);
          chk("act_row", wr_addr, exp_row);
        end
        CMD_WR: begin
          chk("wr_gap", beats_left, 0);
          chk("wr_col", wr_addr, exp_col);
          exp_col    = (exp_col + BL) % (1 << CW);
          beats_left = BL;
        end
        CMD_PRE: chk("pre_a10", wr_addr[10], 1);
        CMD_NOP: ;
        default: chk("cmd_legal", wr_cmd, CMD_NOP);
      endcase
      chk("oe", wr_dq_oe, beats_left > 0);
      chk("rd", wr_data_rd, beats_left > 0);
      if (beats_left > 0) begin
        chk("dq", wr_dq, wr_data);
        beats_left--;
      end
      // a job ending on column 0 has written the whole row
      if (flag_wr_end && exp_col == 0) begin
        exp_row = (exp_row + 1) % (1 << RW);
        if (exp_row == 0) exp_bank = (exp_bank + 1) % 4;
      end
    end
  end

  // Model for the one-burst-per-row instance
  int m2_row = 0, m2_bank = 0, s2_flags = 0;
  always @(negedge sclk) begin
    if (s2_rst_n) begin
      if (s2_cmd == CMD_ACT) begin
        chk("s2_act_row", s2_addr, m2_row);
        chk("s2_act_bank", s2_bank, m2_bank);
      end
      if (s2_flag) begin
        s2_flags++;
        m2_row = (m2_row + 1) % (1 << RW);
        if (m2_row == 0) m2_bank = (m2_bank + 1) % 4;
      end
    end
  end

  task automatic pulse_trig();
    wr_trig = 1'b1;
    @(negedge sclk);
    wr_trig = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      @(negedge sclk);
      n++;
    end
    chk("req_seen", wr_req, 1);
  endtask

  // Grant after dly cycles, run to flag_wr_end; cycle numbers count from the
  // grant cycle (0). Optional wr_en drop, refresh raise and stray trig.
  task automatic grant_job(input int dly, input int drop_at, input int ref_at,
                           input int trig_at, output int beats, output int lcyc,
                           output int pcyc, output int fcyc);
    int cyc;
    beats = 0; lcyc = -1; pcyc = -1; fcyc = -1; cyc = 0;
    repeat (dly) @(negedge sclk);
    wr_en = 1'b1;
    while (fcyc < 0 && cyc < 1000) begin
      @(negedge sclk);
      cyc++;
      if (cyc == drop_at) wr_en = 1'b0;
      if (cyc == ref_at) ref_req = 1'b1;
      wr_trig = (cyc == trig_at);
      if (cyc == 1) chk("act_at_1", wr_cmd, CMD_ACT);
      if (cyc == 3) chk("wr_at_3", wr_cmd, CMD_WR);
      chk("req_low", wr_req, 0);
      if (wr_dq_oe) begin
        beats++;
        lcyc = cyc;
      end
      if (wr_cmd == CMD_PRE) pcyc = cyc;
      if (flag_wr_end) fcyc = cyc;
    end
    wr_en = 1'b0; ref_req = 1'b0; wr_trig = 1'b0;
    if (fcyc < 0) chk("flag_timeout", 0, 1);
  endtask

  initial begin
    int beats, lcyc, pcyc, fcyc, n;
    repeat (2) @(negedge sclk);
    chk("rst_cmd", wr_cmd, CMD_NOP);
    chk("rst_req", wr_req, 0);
    chk("rst_busy", wr_busy, 0);
    chk("rst_oe", wr_dq_oe, 0);
    chk("rst_rd", wr_data_rd, 0);
    chk("rst_flag", flag_wr_end, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_bank", wr_bank, 0);
    chk("rst_dq", wr_dq, 0);
    s_rst_n = 1'b1; s2_rst_n = 1'b1;
    @(negedge sclk);

    fork
      begin
        // full row 0, grant two cycles after request
        pulse_trig();
        wait_req();
        chk("busy_job1", wr_busy, 1);
        grant_job(2, 0, 0, 0, beats, lcyc, pcyc, fcyc);
        chk("j1_beats", beats, 512);
        chk("j1_pre_lat", pcyc - lcyc, 2);
        chk("j1_flag_lat", fcyc - lcyc, 5);
        @(negedge sclk);
        chk("j1_idle", wr_busy, 0);

        // row 1: wr_en dropped mid-write, stray trig while busy
        pulse_trig();
        wait_req();
        grant_job($urandom_range(0, 3), $urandom_range(10, 200), 0, 300,
                  beats, lcyc, pcyc, fcyc);
        chk("j2_beats", beats, 512);
        chk("j2_flag_lat", fcyc - lcyc, 5);
        @(negedge sclk);
        chk("j2_idle", wr_busy, 0);
        repeat (5) @(negedge sclk);
        chk("no_extra_job", wr_busy, 0);

        // row 2: refresh breaks after burst 5, resume at column 24
        pulse_trig();
        wait_req();
        grant_job(2, 0, $urandom_range(23, 26), 0, beats, lcyc, pcyc, fcyc);
        chk("brk_beats", beats, 24);
        chk("brk_pre_lat", pcyc - lcyc, 2);
        chk("brk_flag_lat", fcyc - lcyc, 5);
        @(negedge sclk);
        chk("brk_busy", wr_busy, 1);
        chk("brk_rereq", wr_req, 1);
        grant_job($urandom_range(0, 3), 0, 0, 0, beats, lcyc, pcyc, fcyc);
        chk("resume_beats", beats, 488);
        @(negedge sclk);
        chk("resume_idle", wr_busy, 0);

        // row 3: reset during a WRITE command
        pulse_trig();
        wait_req();
        wr_en = 1'b1;
        n = 0;
        while (n < 80 && !(n >= 30 && wr_cmd == CMD_WR)) begin
          @(negedge sclk);
          n++;
        end
        chk("rst_found_wr", wr_cmd, CMD_WR);
        #2 s_rst_n = 1'b0;
        #1;
        chk("arst_cmd", wr_cmd, CMD_NOP);
        chk("arst_oe", wr_dq_oe, 0);
        chk("arst_req", wr_req, 0);
        chk("arst_busy", wr_busy, 0);
        wr_en = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);

        // counters cleared: row 0 again, column 0
        pulse_trig();
        wait_req();
        grant_job($urandom_range(0, 3), 0, 0, 0, beats, lcyc, pcyc, fcyc);
        chk("post_rst_beats", beats, 512);
      end
      begin
        // one burst per row: 4097 jobs cross row 4095 -> row 0, bank 1
        s2_en = 1'b1;
        for (int j = 0; j < NJOB2; j++) begin
          int k;
          s2_trig = 1'b1;
          @(negedge sclk);
          s2_trig = 1'b0;
          k = 0;
          while (!s2_flag && k < 40) begin
            @(negedge sclk);
            k++;
          end
          if (!s2_flag) begin
            chk("s2_flag_timeout", 0, 1);
            break;
          end
          @(negedge sclk);
        end
        chk("s2_jobs", s2_flags, NJOB2);
        chk("s2_bank_after", m2_bank, 1);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
